// File: rtl/rdma_remap.sv
`default_nettype none
// ============================================================================
// Module   : rdma_remap
// Purpose  : Registered local-to-remote address translator for the RDMA
//            path. Adds a fixed window offset modulo 2^ADDR_W and raises a
//            one-cycle ready strobe for every accepted request.
// Revision : 1.0 - initial release
// ============================================================================
module rdma_remap #(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] REMOTE_OFFSET = 32'h8000_0000
) (
  input  logic              clk,
  // Synchronous reset, active HIGH despite the _n suffix (legacy name).
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] local_addr,
  output logic [ADDR_W-1:0] remote_addr,
  output logic              ready
);

  logic [ADDR_W-1:0] remote_addr_q, remote_addr_d;
  logic              ready_q, ready_d;

  // Next-state: translate on start, otherwise hold the address and drop ready.
  // The sum is ADDR_W wide, so the carry out of the top bit is discarded.
  always_comb begin
    remote_addr_d = remote_addr_q;
    ready_d       = 1'b0;
    if (start) begin
      remote_addr_d = local_addr + REMOTE_OFFSET;
      ready_d       = 1'b1;
    end
  end

  // Output registers; reset takes priority over a simultaneous start.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      remote_addr_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      remote_addr_q <= remote_addr_d;
      ready_q       <= ready_d;
    end
  end

  assign remote_addr = remote_addr_q;
  assign ready       = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_rdma_remap.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdma_remap
// Purpose  : Self-checking bench for rdma_remap: directed boundary cases with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdma_remap;

  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] OFFSET = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] local_addr = '0;
  logic [ADDR_W-1:0] remote_addr;
  logic              ready;

  int checks = 0;
  int errors = 0;

  // Behavioural expectation of the outputs
  logic [31:0] m_addr = '0;
  logic        m_rdy = 1'b0;
  logic        m_valid = 1'b0;

  rdma_remap #(.ADDR_W(ADDR_W), .REMOTE_OFFSET(OFFSET)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .local_addr (local_addr),
    .remote_addr(remote_addr),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  // Reference: translation as plain modular arithmetic on wide integers.
  always @(posedge clk) begin
    longint unsigned sum;
    sum = (longint'(local_addr) + longint'(OFFSET)) % 64'h1_0000_0000;
    m_valid <= 1'b1;
    if (rst_n) begin
      m_addr <= 32'h0;
      m_rdy  <= 1'b0;
    end else if (start) begin
      m_addr <= sum[31:0];
      m_rdy  <= 1'b1;
    end else begin
      m_rdy  <= 1'b0;
    end
  end

  // Compare process: every falling edge once the model is defined.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (remote_addr !== m_addr || ready !== m_rdy) begin
        errors++;
        $display("FAIL model t=%0t addr got %h exp %h ready got %b exp %b",
                 $time, remote_addr, m_addr, ready, m_rdy);
      end
    end
  end

  // Drive one cycle of inputs (from a falling edge), then sample at next negedge.
  task automatic step(input logic r, input logic s, input logic [31:0] a);
    rst_n      = r;
    start      = s;
    local_addr = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [31:0] ea, input logic er);
    checks++;
    if (remote_addr !== ea || ready !== er) begin
      errors++;
      $display("FAIL %s addr got %h exp %h ready got %b exp %b",
               name, remote_addr, ea, ready, er);
    end
  endtask

  initial begin
    // Reset held with a live request: outputs stay cleared.
    step(1'b1, 1'b1, 32'h1234);       lit("reset_c1", 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h1234);       lit("reset_c2", 32'h0, 1'b0);

    step(1'b0, 1'b1, 32'h0000_1000);  lit("basic",     32'h8000_1000, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_0000);  lit("wrap_ffff", 32'h7FFF_0000, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0000);  lit("zero",      32'h8000_0000, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);  lit("top",       32'h7FFF_FFFF, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0000);  lit("msb_only",  32'h0000_0000, 1'b1);
    step(1'b0, 1'b1, 32'h7FFF_FFFF);  lit("upper",     32'hFFFF_FFFF, 1'b1);

    // Idle gap, then four back-to-back requests.
    step(1'b0, 1'b0, 32'hDEAD_BEEF);  lit("idle_hold", 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0010);  lit("b2b_0",     32'h8000_0010, 1'b1);
    step(1'b0, 1'b1, 32'h8000_0001);  lit("b2b_1",     32'h0000_0001, 1'b1);
    step(1'b0, 1'b1, 32'h1234_5678);  lit("b2b_2",     32'h9234_5678, 1'b1);
    step(1'b0, 1'b1, 32'h7FFF_FFFF);  lit("b2b_3",     32'hFFFF_FFFF, 1'b1);
    step(1'b0, 1'b0, 32'h0000_0042);  lit("drop_1",    32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b0, 32'h0000_0043);  lit("drop_2",    32'hFFFF_FFFF, 1'b0);

    // Reset wins over a simultaneous request.
    step(1'b1, 1'b1, 32'h0000_1000);  lit("rst_prio",  32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0005);  lit("post_rst",  32'h8000_0005, 1'b1);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom());
    end

    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rdma_remap.md
# rdma_remap

Single-cycle registered address translator for the RDMA path. It converts a local memory address into the remote node's address space by adding a fixed window offset, modulo 2^ADDR_W. It sits between the local request generator and the RDMA send engine. Every accepted request produces one translated address and a one-cycle `ready` strobe.

## Interface

Parameters:
- `ADDR_W`, 32: address width in bits.
- `REMOTE_OFFSET`, 32'h8000_0000: constant added to the local address; ADDR_W bits wide.

Ports:
- `clk`  input  1: single clock; all logic is rising-edge triggered.
- `rst_n`  input  1: synchronous, active-high reset. It is sampled on the rising edge of `clk`, and the block is in reset while `rst_n` = 1. The name is kept for codebase consistency; the polarity is high.
- `start`  input  1: request valid, sampled on each rising edge.
- `local_addr`  input  ADDR_W: local address, sampled when `start` = 1.
- `remote_addr`  output  ADDR_W: registered translated address.
- `ready`  output  1: registered strobe; 1 for exactly the cycle after each accepted request.

## Operation

- Translation: `remote_addr = (local_addr + REMOTE_OFFSET) mod 2^ADDR_W`.
  - Unsigned addition; the carry out of bit ADDR_W-1 is discarded.
  - No saturation and no error flag.
  - With the default offset, this is equivalent to inverting the MSB.
- On each rising edge, with priority top-down:
  - Reset (`rst_n` = 1): `remote_addr` <= 0, `ready` <= 0.
  - `start` = 1: `remote_addr` <= translated `local_addr`, `ready` <= 1.
  - Otherwise: `remote_addr` holds its last value, `ready` <= 0.
- No internal state beyond the two output registers; no FSM and no backpressure.
- `start` needs no handshake. Every cycle with `start` = 1 is a new, independent request.
- `local_addr` is don't-care when `start` = 0.

## Timing

- Reset values: `remote_addr` = 0, `ready` = 0. Both are cleared on the first rising edge with `rst_n` = 1.
- Latency is 1 cycle:
  - Inputs are sampled at edge N.
  - Results are visible after edge N and stay stable until edge N+1.
- Throughput: one translation per cycle.
  - With `start` held high, `ready` stays 1 continuously.
  - `remote_addr` updates every cycle to track `local_addr` of the previous edge.
- Reset mid-stream: reset wins over a simultaneous `start`. That request is dropped, and outputs are 0 on the next cycle.
- First request after reset deassertion: accepted on the first edge where `rst_n` = 0 and `start` = 1.
- Wrap-around at the address-space top:
  - Local 32'hFFFF_FFFF maps to 32'h7FFF_FFFF.
  - Local 32'h8000_0000 maps to 32'h0000_0000.
- `remote_addr` is a pure register output with no combinational path from any input.

## Test plan

- Reset: hold `rst_n` = 1 for 2 cycles with `start` = 1 and `local_addr` = 32'h1234 -> `remote_addr` = 0 and `ready` = 0 throughout.
- Basic: after reset, `start` = 1 with `local_addr` = 32'h0000_1000 -> one edge later, `remote_addr` = 32'h8000_1000 and `ready` = 1.
- Wrap: `local_addr` = 32'hFFFF_0000 -> 32'h7FFF_0000. Also check 32'h0000_0000 -> 32'h8000_0000.
- Upper boundary: `local_addr` = 32'h7FFF_FFFF -> 32'hFFFF_FFFF.
- Back-to-back and hold, then drop `start`:
  - Drive 4 addresses on consecutive cycles with `start` high -> `ready` = 1 for 4 cycles and each `remote_addr` is correct one cycle after its input.
  - Then drop `start` -> `ready` = 0 and `remote_addr` holds 32'hFFFF_FFFF.
- Reset priority: assert `rst_n` = 1 in the same cycle as `start` = 1 with `local_addr` = 32'h1000 -> next cycle `remote_addr` = 0 and `ready` = 0.
